// File: rtl/ddfs_voice_mixer.sv
// ddfs_voice_mixer: round-robin gain/mute mixer of NV voice samples into one saturated 16-bit stream
module ddfs_voice_mixer #(
  parameter int NV = 8,
  parameter int GW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic               read,
  input  logic               write,
  input  logic [4:0]         addr,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  input  logic [NV*16-1:0]   pcm_in,
  output logic [15:0]        pcm_out,
  output logic               pcm_valid,
  output logic               clip
);
  localparam int VW = $clog2(NV);
  localparam int PW = GW + 10;
  localparam int RW = GW + 17;
  localparam int AW = PW + VW;
  localparam logic [4:0] NVA = 5'(NV);
  logic [VW-1:0] vi;
  logic [GW-1:0] gain [NV];
  logic [NV-1:0] mute;
  logic [1:0] shift;
  logic [15:0] clipcnt;
  logic signed [15:0] s1_smp;
  logic [GW-1:0] s1_g;
  logic s1_last;
  logic signed [PW-1:0] s2_p;
  logic s2_last;
  logic signed [AW-1:0] acc, sum, m;
  logic signed [RW-1:0] prod;
  logic clip_n;
  logic [15:0] sat;
  logic wr;
  logic unused_ok;
  assign wr = cs & write;
  assign unused_ok = ^{read, wr_data};
  always_comb begin
    prod = RW'(s1_smp) * RW'($signed({1'b0, s1_g}));
    sum = acc + {{VW{s2_p[PW-1]}}, s2_p};
    m = sum >>> shift;
    clip_n = m[AW-1:15] != {(AW-15){m[15]}};
    sat = clip_n ? {m[AW-1], {15{~m[AW-1]}}} : m[15:0];
    rd_data = addr < NVA ? 32'(gain[addr[VW-1:0]]) :
              addr == 5'd8 ? 32'(mute) :
              addr == 5'd9 ? 32'(shift) :
              addr == 5'd10 ? {16'h0, pcm_out} :
              addr == 5'd11 ? {16'h0, clipcnt} : 32'h0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NV; i++) gain[i] <= {1'b1, {(GW-1){1'b0}}};
      mute <= '0;
      shift <= 2'd3;
      clipcnt <= '0;
    end else begin
      if (wr && addr < NVA) gain[addr[VW-1:0]] <= wr_data[GW-1:0];
      if (wr && addr == 5'd8) mute <= wr_data[NV-1:0];
      if (wr && addr == 5'd9) shift <= wr_data[1:0];
      // a clear on the same edge as a clipping frame wins over the increment
      if (wr && addr == 5'd11) clipcnt <= '0;
      else if (s2_last && clip_n && clipcnt != 16'hFFFF) clipcnt <= clipcnt + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vi <= '0;
      s1_smp <= '0;
      s1_g <= '0;
      s1_last <= 1'b0;
      s2_p <= '0;
      s2_last <= 1'b0;
      acc <= '0;
      pcm_out <= '0;
      pcm_valid <= 1'b0;
      clip <= 1'b0;
    end else begin
      vi <= vi + 1'b1;
      s1_smp <= mute[vi] ? '0 : pcm_in[{vi, 4'b0} +: 16];
      s1_g <= gain[vi];
      s1_last <= &vi;
      s2_p <= PW'(prod >>> 7);
      s2_last <= s1_last;
      acc <= s2_last ? '0 : sum;
      pcm_valid <= s2_last;
      if (s2_last) begin
        pcm_out <= sat;
        clip <= clip_n;
      end
    end
  end
endmodule

// File: tb/tb_ddfs_voice_mixer.sv
// tb_ddfs_voice_mixer: table-driven frames checked through a scoreboard, plus timing/clipcnt/reset sequences
module tb_ddfs_voice_mixer;
  logic clk = 1'b0;
  logic reset, cs, read, write;
  logic [4:0] addr;
  logic [31:0] wr_data, rd_data;
  logic [127:0] pcm_in;
  logic [15:0] pcm_out;
  logic pcm_valid, clip;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [127:0] pcm;
    logic [63:0] gain;
    logic [7:0] mute;
    logic [1:0] shift;
    logic [15:0] out;
    logic clip;
  } vec_t;
  typedef struct packed {
    logic [15:0] out;
    logic clip;
    logic [7:0] id;
  } exp_t;
  exp_t q[$];
  vec_t v[13];
  localparam logic [63:0] G80 = {8{8'h80}};

  always #5 clk = ~clk;

  ddfs_voice_mixer dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .pcm_in(pcm_in), .pcm_out(pcm_out),
    .pcm_valid(pcm_valid), .clip(clip)
  );

  function automatic logic [127:0] all16(input logic [15:0] x);
    return {8{x}};
  endfunction
  function automatic logic [127:0] one16(input int k, input logic [15:0] x);
    logic [127:0] r;
    r = '0;
    r[k*16 +: 16] = x;
    return r;
  endfunction
  function automatic logic [63:0] setg(input int k, input logic [7:0] g);
    logic [63:0] r;
    r = G80;
    r[k*8 +: 8] = g;
    return r;
  endfunction
  function automatic vec_t mk(input logic [127:0] p, input logic [63:0] g, input logic [7:0] mu,
                              input logic [1:0] sh, input logic [15:0] o, input logic c);
    vec_t t;
    t.pcm = p; t.gain = g; t.mute = mu; t.shift = sh; t.out = o; t.clip = c;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [31:0] e, input string name);
    @(negedge clk);
    addr = a;
    #1;
    check(name, rd_data, e);
  endtask

  task automatic sync_valid;
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!pcm_valid && n < 20);
    if (!pcm_valid) check("sync_valid timeout", 32'(pcm_valid), 32'd1);
  endtask

  task automatic apply(input vec_t t, input int id);
    for (int k = 0; k < 8; k++) wr(5'(k), 32'(t.gain[k*8 +: 8]));
    wr(5'd8, 32'(t.mute));
    wr(5'd9, 32'(t.shift));
    pcm_in = t.pcm;
    repeat (3) sync_valid;
    q.push_back('{t.out, t.clip, 8'(id)});
    @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) check("scoreboard drain", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  always @(negedge clk) begin
    if (pcm_valid && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check($sformatf("vec%0d pcm_out", e.id), 32'(pcm_out), 32'(e.out));
      check($sformatf("vec%0d clip", e.id), 32'(clip), 32'(e.clip));
    end
  end

  initial begin
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    pcm_in = one16(0, 16'd8000);
    v[0]  = mk(all16(16'h7FFF), G80, 8'h00, 2'd0, 16'h7FFF, 1'b1);
    v[1]  = mk(all16(16'h7FFF), G80, 8'h00, 2'd3, 16'h7FFF, 1'b0);
    v[2]  = mk(all16(16'h8000), G80, 8'h00, 2'd0, 16'h8000, 1'b1);
    v[3]  = mk(one16(2, -16'sd2000), setg(2, 8'h40), 8'h00, 2'd0, -16'sd1000, 1'b0);
    v[4]  = mk(one16(5, 16'd1000), setg(5, 8'hFF), 8'h00, 2'd0, 16'd1992, 1'b0);
    v[5]  = mk(all16(16'd1000), 64'h0, 8'h00, 2'd0, 16'd0, 1'b0);
    v[6]  = mk(one16(0, 16'd1000), G80, 8'h01, 2'd0, 16'd0, 1'b0);
    v[7]  = mk(one16(0, 16'd1000), G80, 8'h00, 2'd0, 16'd1000, 1'b0);
    v[8]  = mk(one16(1, 16'hFFFF) | one16(3, 16'h0001), 64'h8080_8080_0180_0180, 8'h00, 2'd0, 16'hFFFF, 1'b0);
    v[9]  = mk(one16(1, 16'hFFFF) | one16(3, 16'h0001), 64'h8080_8080_0180_0180, 8'h00, 2'd1, 16'hFFFF, 1'b0);
    v[10] = mk(all16(16'd1000), G80, 8'h00, 2'd2, 16'd2000, 1'b0);
    v[11] = mk(all16(16'd1000), G80, 8'hAA, 2'd0, 16'd4000, 1'b0);
    v[12] = mk(all16(16'h7FFF), {8{8'hFF}}, 8'h00, 2'd3, 16'h7FFF, 1'b1);
    repeat (3) @(negedge clk);
    check("reset pcm_out", 32'(pcm_out), 32'd0);
    check("reset pcm_valid", 32'(pcm_valid), 32'd0);
    check("reset clip", 32'(clip), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    // default gain 1.0 and shift 3: voice0=8000 mixes to 1000
    for (int n = 1; n <= 18; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("valid cycle %0d", n), 32'(pcm_valid), 32'(n == 10 || n == 18));
      if (n == 10) check("first frame out", 32'(pcm_out), 32'd1000);
    end
    for (int k = 0; k < 8; k++) rd_chk(5'(k), 32'h80, $sformatf("reset gain%0d", k));
    rd_chk(5'd8, 32'd0, "reset mute");
    rd_chk(5'd9, 32'd3, "reset shift");
    rd_chk(5'd10, 32'd1000, "last");
    rd_chk(5'd11, 32'd0, "reset clipcnt");
    rd_chk(5'd12, 32'd0, "unmapped 12");
    rd_chk(5'd31, 32'd0, "unmapped 31");
    for (int i = 0; i < 13; i++) apply(v[i], i);
    pcm_in = all16(16'h7FFF);
    for (int k = 0; k < 8; k++) wr(5'(k), 32'h80);
    wr(5'd8, 32'd0);
    wr(5'd9, 32'd0);
    repeat (2) sync_valid;
    sync_valid;
    wr(5'd11, 32'd0);
    sync_valid;
    rd_chk(5'd11, 32'd1, "clipcnt after 1 frame");
    sync_valid;
    rd_chk(5'd11, 32'd2, "clipcnt after 2 frames");
    // land the clear on the same edge that registers the next clipping frame
    repeat (7) @(posedge clk);
    wr(5'd11, 32'hFFFF_FFFF);
    check("coincident valid", 32'(pcm_valid), 32'd1);
    check("coincident clip", 32'(clip), 32'd1);
    rd_chk(5'd11, 32'd0, "clipcnt clear wins");
    sync_valid;
    rd_chk(5'd11, 32'd1, "clipcnt after clear");
    pcm_in = all16(16'd800);
    sync_valid;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midreset pcm_out", 32'(pcm_out), 32'd0);
    check("midreset pcm_valid", 32'(pcm_valid), 32'd0);
    check("midreset clip", 32'(clip), 32'd0);
    rd_chk(5'd9, 32'd3, "midreset shift");
    rd_chk(5'd11, 32'd0, "midreset clipcnt");
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("post-reset valid cycle %0d", n), 32'(pcm_valid), 32'(n == 10));
      if (n == 10) begin
        check("post-reset full frame", 32'(pcm_out), 32'd800);
        check("post-reset clip", 32'(clip), 32'd0);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
